uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_serializer.sv | 119 +++++++++++
 tb/tb_uart_tx_serializer.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Constants and state type shared by the UART transmit serializer and the receive-side assembler.
package uart_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

    // Byte idx of a word, LSB first; indices past the word return zero.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                    input logic [IDX_W-1:0]  idx);
        word_byte = BYTE_W'(word >> (BYTE_W * int'(idx)));
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Splits 32-bit words into LSB-first bytes for a byte UART, handshaking via tx_start/tx_done.
// Define UART_TX_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte after byte3.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] tx_word,
    input  logic              tx_word_valid,
    output logic              tx_word_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_byte,
    input  logic              tx_done,
    output logic              busy,
    output logic              word_done
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
`ifdef UART_TX_SERIALIZER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
`endif

    tx_state_e         state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        gap_q, gap_d;
    logic              done_q, done_d;
    logic              word_done_q, word_done_d;
    logic [BYTE_W-1:0] cur_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            done_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
            word_done_q <= word_done_d;
        end
    end

`ifdef UART_TX_SERIALIZER_CHECKSUM_EN
    always_comb begin
        cur_byte = word_byte(hold_q, idx_q);
        if (idx_q == LAST_IDX) begin
            cur_byte = '0;
            for (int i = 0; i < WORD_BYTES; i++) begin
                cur_byte = cur_byte ^ hold_q[i*BYTE_W +: BYTE_W];
            end
        end
    end
`else
    assign cur_byte = word_byte(hold_q, idx_q);
`endif

    // tx_done is registered only while waiting, so pulses in IDLE/START/GAP never count
    // and the next byte starts two cycles after the done pulse.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        done_d      = tx_done && (state_q == WAIT);
        word_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_word_valid) begin
                    hold_d  = tx_word;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (done_q) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d       = '0;
                        word_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end else begin
                            state_d = START;
                        end
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    gap_d   = '0;
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_word_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign tx_start      = (state_q == START);
    assign tx_byte       = (state_q == IDLE) ? '0 : cur_byte;
    assign word_done     = word_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: instance 0 with no gap, instance 1 with a 3-cycle gap,
// each driven by a byte-UART responder that answers tx_start with tx_done after a latency.
module tb_uart_tx_serializer;

`ifdef UART_TX_SERIALIZER_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int GAP1  = 3;
    localparam int BOUND = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tx_word [2];
    logic [7:0]  tx_byte [2];
    logic [1:0]  tx_word_valid, tx_word_ready, tx_start, tx_done, busy, word_done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int lat [2];
    int cnt [2];
    bit [1:0] spur;

    int         start_cyc  [2][$];
    logic [7:0] start_byte [2][$];
    int         done_cyc   [2][$];
    int         wd_cyc     [2][$];
    int         exp_start [$];
    logic [7:0] exp_byte  [$];
    int         exp_wd    [$];

    uart_tx_serializer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .tx_word(tx_word[0]), .tx_word_valid(tx_word_valid[0]),
        .tx_word_ready(tx_word_ready[0]), .tx_start(tx_start[0]), .tx_byte(tx_byte[0]),
        .tx_done(tx_done[0]), .busy(busy[0]), .word_done(word_done[0])
    );

    uart_tx_serializer #(.GAP_CYCLES(GAP1)) dut1 (
        .clk(clk), .rst(rst), .tx_word(tx_word[1]), .tx_word_valid(tx_word_valid[1]),
        .tx_word_ready(tx_word_ready[1]), .tx_start(tx_start[1]), .tx_byte(tx_byte[1]),
        .tx_done(tx_done[1]), .busy(busy[1]), .word_done(word_done[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte UART model and event logger, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tx_done[d] = 1'b0;
            if (rst) begin
                cnt[d] = 0;
            end else begin
                if (cnt[d] > 0) begin
                    cnt[d] = cnt[d] - 1;
                    if (cnt[d] == 0) begin
                        tx_done[d] = 1'b1;
                        done_cyc[d].push_back(cyc);
                    end
                end
                if (tx_start[d]) begin
                    start_cyc[d].push_back(cyc);
                    start_byte[d].push_back(tx_byte[d]);
                    cnt[d] = lat[d];
                end
                if (spur[d] && (!busy[d] || tx_start[d])) tx_done[d] = 1'b1;
                if (word_done[d]) wd_cyc[d].push_back(cyc);
            end
        end
    end

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : GAP1;
    endfunction

    // Reference: bytes LSB first (plus XOR checksum), first start one cycle after accept,
    // each later start two cycles plus the gap after the done, word_done two after the last done.
    task automatic model_word(input logic [31:0] w, input int acc, input int l, input int g);
        int t;
        logic [7:0] b, cs;
        t  = acc + 1;
        cs = 8'h00;
        for (int i = 0; i < NB; i++) begin
            b  = (i < 4) ? 8'((w >> (8 * i)) & 32'hFF) : cs;
            cs = cs ^ b;
            exp_byte.push_back(b);
            exp_start.push_back(t);
            t = t + l + 2 + g;
        end
        exp_wd.push_back(t - g);
    endtask

    task automatic clear_logs(input int d);
        start_cyc[d].delete();
        start_byte[d].delete();
        done_cyc[d].delete();
        wd_cyc[d].delete();
        exp_start.delete();
        exp_byte.delete();
        exp_wd.delete();
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic drive_word(input int d, input logic [31:0] w, input bit hold, output int acc);
        int k;
        tx_word[d]       = w;
        tx_word_valid[d] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!tx_word_ready[d] && k < BOUND) begin
            k++;
            @(negedge clk);
        end
        acc = cyc;
        checks++;
        if (!tx_word_ready[d]) begin
            errors++;
            $display("FAIL accept_timeout dut%0d word %08h never accepted within %0d cycles", d, w, BOUND);
        end
        @(posedge clk);
        #1;
        if (!hold) tx_word_valid[d] = 1'b0;
    endtask

    task automatic wait_words(input int d, input int n, input string tag);
        int k;
        k = 0;
        while (wd_cyc[d].size() < n && k < BOUND) begin
            k++;
            @(negedge clk);
        end
        checks++;
        if (wd_cyc[d].size() < n) begin
            errors++;
            $display("FAIL %s_timeout word_done count %0d, required %0d", tag, wd_cyc[d].size(), n);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_word_valid = 2'b00;
        tx_word[0] = 32'h0;
        tx_word[1] = 32'h0;
        spur = 2'b00;
        lat[0] = 10;
        lat[1] = 10;
        #23;
        for (int d = 0; d < 2; d++) begin
            checks += 4;
            if (tx_start[d] !== 1'b0) begin errors++; $display("FAIL rst_tx_start dut%0d got %b want 0", d, tx_start[d]); end
            if (tx_byte[d] !== 8'h00) begin errors++; $display("FAIL rst_tx_byte dut%0d got %02h want 00", d, tx_byte[d]); end
            if (busy[d] !== 1'b0) begin errors++; $display("FAIL rst_busy dut%0d got %b want 0", d, busy[d]); end
            if (word_done[d] !== 1'b0) begin errors++; $display("FAIL rst_word_done dut%0d got %b want 0", d, word_done[d]); end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (tx_word_ready[d] !== 1'b1) begin errors++; $display("FAIL rst_ready dut%0d got %b want 1", d, tx_word_ready[d]); end
        end
    endtask

    task automatic test_basic();
        int acc;
        lat[0] = 10;
        clear_logs(0);
        drive_word(0, 32'h3F80_0000, 1'b0, acc);
        model_word(32'h3F80_0000, acc, 10, 0);
        wait_words(0, 1, "basic");
        checks++;
        if (start_byte[0].size() !== exp_byte.size()) begin
            errors++; $display("FAIL basic_starts got %0d want %0d", start_byte[0].size(), exp_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < start_byte[0].size(); i++) begin
            checks++;
            if (start_byte[0][i] !== exp_byte[i] || start_cyc[0][i] !== exp_start[i]) begin
                errors++;
                $display("FAIL basic_byte%0d got %02h@%0d want %02h@%0d", i, start_byte[0][i], start_cyc[0][i], exp_byte[i], exp_start[i]);
            end
        end
        checks++;
        if (wd_cyc[0].size() !== 1 || wd_cyc[0][0] !== exp_wd[0]) begin
            errors++; $display("FAIL basic_word_done got %0d pulses first@%0d want 1@%0d", wd_cyc[0].size(), wd_cyc[0].size() > 0 ? wd_cyc[0][0] : -1, exp_wd[0]);
        end
    endtask

    task automatic test_gap();
        int acc;
        lat[1] = 4;
        clear_logs(1);
        drive_word(1, 32'hDEAD_BEEF, 1'b0, acc);
        model_word(32'hDEAD_BEEF, acc, 4, GAP1);
        wait_words(1, 1, "gap");
        checks++;
        if (start_byte[1].size() !== exp_byte.size()) begin
            errors++; $display("FAIL gap_starts got %0d want %0d", start_byte[1].size(), exp_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < start_byte[1].size(); i++) begin
            checks++;
            if (start_byte[1][i] !== exp_byte[i] || start_cyc[1][i] !== exp_start[i]) begin
                errors++;
                $display("FAIL gap_byte%0d got %02h@%0d want %02h@%0d", i, start_byte[1][i], start_cyc[1][i], exp_byte[i], exp_start[i]);
            end
        end
        checks++;
        if (wd_cyc[1].size() !== 1 || wd_cyc[1][0] !== exp_wd[0]) begin
            errors++; $display("FAIL gap_word_done got %0d pulses want 1@%0d", wd_cyc[1].size(), exp_wd[0]);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1;
        lat[0] = 3;
        clear_logs(0);
        drive_word(0, 32'h1122_3344, 1'b1, a0);
        model_word(32'h1122_3344, a0, 3, 0);
        drive_word(0, 32'h5566_7788, 1'b0, a1);
        checks++;
        if (a1 !== exp_wd[0]) begin
            errors++; $display("FAIL b2b_accept_cycle got %0d want %0d", a1, exp_wd[0]);
        end
        model_word(32'h5566_7788, a1, 3, 0);
        wait_words(0, 2, "b2b");
        checks++;
        if (start_byte[0].size() !== exp_byte.size()) begin
            errors++; $display("FAIL b2b_starts got %0d want %0d", start_byte[0].size(), exp_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < start_byte[0].size(); i++) begin
            checks++;
            if (start_byte[0][i] !== exp_byte[i] || start_cyc[0][i] !== exp_start[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d got %02h@%0d want %02h@%0d", i, start_byte[0][i], start_cyc[0][i], exp_byte[i], exp_start[i]);
            end
        end
        checks++;
        if (wd_cyc[0].size() !== 2) begin
            errors++; $display("FAIL b2b_word_done got %0d pulses want 2", wd_cyc[0].size());
        end
    endtask

    task automatic test_spurious();
        int acc;
        logic [31:0] w;
        w = $urandom;
        lat[0] = 5;
        clear_logs(0);
        spur[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b0 || tx_word_ready[0] !== 1'b1) begin
            errors++; $display("FAIL spur_idle busy %b ready %b want 0 1", busy[0], tx_word_ready[0]);
        end
        drive_word(0, w, 1'b0, acc);
        model_word(w, acc, 5, 0);
        wait_words(0, 1, "spur");
        spur[0] = 1'b0;
        checks++;
        if (start_byte[0].size() !== exp_byte.size()) begin
            errors++; $display("FAIL spur_starts got %0d want %0d", start_byte[0].size(), exp_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < start_byte[0].size(); i++) begin
            checks++;
            if (start_byte[0][i] !== exp_byte[i] || start_cyc[0][i] !== exp_start[i]) begin
                errors++;
                $display("FAIL spur_byte%0d got %02h@%0d want %02h@%0d", i, start_byte[0][i], start_cyc[0][i], exp_byte[i], exp_start[i]);
            end
        end
    endtask

    task automatic test_reset_midword();
        int acc, k;
        lat[0] = 6;
        clear_logs(0);
        drive_word(0, 32'hCAFE_BABE, 1'b0, acc);
        k = 0;
        while (done_cyc[0].size() < 2 && k < BOUND) begin k++; @(negedge clk); end
        k = 0;
        while (!tx_start[0] && k < BOUND) begin k++; @(negedge clk); end
        checks++;
        if (!tx_start[0]) begin
            errors++; $display("FAIL midrst_third_start never seen, got %0d starts", start_cyc[0].size());
        end
        #1;
        rst = 1'b1;
        #1;
        checks += 3;
        if (tx_start[0] !== 1'b0) begin errors++; $display("FAIL midrst_tx_start got %b want 0", tx_start[0]); end
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy[0]); end
        if (tx_byte[0] !== 8'h00) begin errors++; $display("FAIL midrst_tx_byte got %02h want 00", tx_byte[0]); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (wd_cyc[0].size() !== 0) begin
            errors++; $display("FAIL midrst_word_done got %0d pulses want 0", wd_cyc[0].size());
        end
        clear_logs(0);
        drive_word(0, 32'h0102_0304, 1'b0, acc);
        model_word(32'h0102_0304, acc, 6, 0);
        wait_words(0, 1, "postrst");
        checks++;
        if (start_byte[0].size() !== exp_byte.size()) begin
            errors++; $display("FAIL postrst_starts got %0d want %0d", start_byte[0].size(), exp_byte.size());
        end
        for (int i = 0; i < exp_byte.size() && i < start_byte[0].size(); i++) begin
            checks++;
            if (start_byte[0][i] !== exp_byte[i] || start_cyc[0][i] !== exp_start[i]) begin
                errors++;
                $display("FAIL postrst_byte%0d got %02h@%0d want %02h@%0d", i, start_byte[0][i], start_cyc[0][i], exp_byte[i], exp_start[i]);
            end
        end
    endtask

    task automatic test_random();
        int acc, l;
        logic [31:0] w;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                l = $urandom_range(1, 6);
                lat[d] = l;
                clear_logs(d);
                for (int n = 0; n < 4; n++) begin
                    w = $urandom;
                    drive_word(d, w, 1'b0, acc);
                    model_word(w, acc, l, gap_of(d));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                wait_words(d, 4, "rand");
                checks++;
                if (start_byte[d].size() !== exp_byte.size() || wd_cyc[d].size() !== 4) begin
                    errors++;
                    $display("FAIL rand_counts dut%0d starts %0d words %0d want %0d 4", d, start_byte[d].size(), wd_cyc[d].size(), exp_byte.size());
                end
                for (int i = 0; i < exp_byte.size() && i < start_byte[d].size(); i++) begin
                    checks++;
                    if (start_byte[d][i] !== exp_byte[i] || start_cyc[d][i] !== exp_start[i]) begin
                        errors++;
                        $display("FAIL rand_dut%0d_byte%0d got %02h@%0d want %02h@%0d", d, i, start_byte[d][i], start_cyc[d][i], exp_byte[i], exp_start[i]);
                    end
                end
                for (int i = 0; i < exp_wd.size() && i < wd_cyc[d].size(); i++) begin
                    checks++;
                    if (wd_cyc[d][i] !== exp_wd[i]) begin
                        errors++; $display("FAIL rand_dut%0d_word_done%0d got %0d want %0d", d, i, wd_cyc[d][i], exp_wd[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_back_to_back();
        test_spurious();
        test_reset_midword();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
